// File: rtl/reg_scoreboard.sv
// Register-reservation scoreboard for the decode stage: per-register pending-write
// counters that raise a decode hazard and take releases from writeback and kills.
module reg_scoreboard #(
  parameter int W_RD   = 5,
  parameter int W_CNT  = 2,
  parameter bit BYPASS = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 v_i,
  input  logic [W_RD-1:0]      r0_i,
  input  logic [W_RD-1:0]      r1_i,
  input  logic                 use_r0_i,
  input  logic                 use_r1_i,
  input  logic                 w_reserve_i,
  input  logic                 issue_i,
  input  logic                 wb_i,
  input  logic [W_RD-1:0]      wb_r_i,
  input  logic                 kill_i,
  input  logic [W_RD-1:0]      kill_r_i,
  input  logic                 flush_i,
  output logic                 reserved_o,
  output logic [2**W_RD-1:0]   busy_o,
  output logic                 idle_o,
  output logic                 err_o
);

  localparam int NREG = 2**W_RD;
  localparam int CW   = W_CNT + 2;
  localparam logic [W_CNT-1:0] CNT_MAX = '1;
  localparam logic [W_CNT-1:0] CNT_ONE = W_CNT'(1);

  logic [W_CNT-1:0] cnt    [NREG];
  logic [W_CNT-1:0] cnt_nx [NREG];
  logic [CW-1:0]    sum    [NREG];
  logic [CW-1:0]    dec    [NREG];
  logic [NREG-1:0]  uflow;
  logic             err;
  logic             pend0;
  logic             pend1;
  logic             dst_full;
  logic             rsv;

  // A writeback retiring the last pending write frees sources in the same cycle.
  always_comb begin
    pend0 = (cnt[r0_i] != '0);
    pend1 = (cnt[r1_i] != '0);
    if (BYPASS && wb_i && (wb_r_i == r0_i) && (cnt[r0_i] == CNT_ONE)) pend0 = 1'b0;
    if (BYPASS && wb_i && (wb_r_i == r1_i) && (cnt[r1_i] == CNT_ONE)) pend1 = 1'b0;
    dst_full = (cnt[r0_i] == CNT_MAX);
  end

  assign reserved_o = v_i & ((use_r0_i & pend0) | (use_r1_i & pend1) | (w_reserve_i & dst_full));
  assign rsv        = v_i & issue_i & w_reserve_i & ~reserved_o & ~flush_i;

  // Net reserve against both releases; a shortfall clamps at zero and flags an error.
  always_comb begin
    uflow = '0;
    for (int n = 0; n < NREG; n++) begin
      sum[n] = CW'(cnt[n]) + CW'(rsv && (r0_i == W_RD'(n)));
      dec[n] = CW'(wb_i && (wb_r_i == W_RD'(n))) + CW'(kill_i && (kill_r_i == W_RD'(n)));
      if (sum[n] < dec[n]) begin
        cnt_nx[n] = '0;
        uflow[n]  = 1'b1;
      end else begin
        cnt_nx[n] = W_CNT'(sum[n] - dec[n]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < NREG; n++) cnt[n] <= '0;
      err <= 1'b0;
    end else begin
      for (int n = 0; n < NREG; n++) cnt[n] <= cnt_nx[n];
      if (|uflow) err <= 1'b1;
    end
  end

  always_comb begin
    busy_o = '0;
    for (int n = 0; n < NREG; n++) busy_o[n] = (cnt[n] != '0);
  end

  assign idle_o = ~|busy_o;
  assign err_o  = err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: a directed vector table, a RAW bypass sequence on both
// BYPASS settings, then random traffic against a counter-array reference model.
module tb_reg_scoreboard;

  localparam int NREG = 32;
  localparam int CMAX = 3;

  logic clk;
  logic reset, v, use_r0, use_r1, w_reserve, issue, wb, kill, flush;
  logic [4:0] r0, r1, wb_r, kill_r;

  logic        res0, res1, idle0, idle1, err0, err1;
  logic [31:0] busy0, busy1;

  int checks = 0;
  int errors = 0;

  int mcnt [2][NREG];
  bit merr [2];

  typedef struct {
    logic rst, v, iss, wres, u0, u1;
    logic [4:0] r0, r1;
    logic wb;
    logic [4:0] wbr;
    logic kl;
    logic [4:0] klr;
    logic fl;
    logic e_res;
    logic [31:0] e_busy;
    logic e_idle, e_err;
  } stim_t;

  stim_t vec [$];

  reg_scoreboard #(.W_RD(5), .W_CNT(2), .BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset), .v_i(v), .r0_i(r0), .r1_i(r1),
    .use_r0_i(use_r0), .use_r1_i(use_r1), .w_reserve_i(w_reserve), .issue_i(issue),
    .wb_i(wb), .wb_r_i(wb_r), .kill_i(kill), .kill_r_i(kill_r), .flush_i(flush),
    .reserved_o(res0), .busy_o(busy0), .idle_o(idle0), .err_o(err0)
  );

  reg_scoreboard #(.W_RD(5), .W_CNT(2), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .v_i(v), .r0_i(r0), .r1_i(r1),
    .use_r0_i(use_r0), .use_r1_i(use_r1), .w_reserve_i(w_reserve), .issue_i(issue),
    .wb_i(wb), .wb_r_i(wb_r), .kill_i(kill), .kill_r_i(kill_r), .flush_i(flush),
    .reserved_o(res1), .busy_o(busy1), .idle_o(idle1), .err_o(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mk(logic rst, logic vv, logic iss, logic wres, logic u0, logic u1,
                               logic [4:0] a0, logic [4:0] a1, logic w, logic [4:0] wr,
                               logic k, logic [4:0] kr, logic fl,
                               logic er, logic [31:0] eb, logic ei, logic ee);
    stim_t s;
    s.rst = rst; s.v = vv; s.iss = iss; s.wres = wres; s.u0 = u0; s.u1 = u1;
    s.r0 = a0; s.r1 = a1; s.wb = w; s.wbr = wr; s.kl = k; s.klr = kr; s.fl = fl;
    s.e_res = er; s.e_busy = eb; s.e_idle = ei; s.e_err = ee;
    return s;
  endfunction

  task automatic apply_stimulus(input stim_t s);
    reset = s.rst; v = s.v; issue = s.iss; w_reserve = s.wres;
    use_r0 = s.u0; use_r1 = s.u1; r0 = s.r0; r1 = s.r1;
    wb = s.wb; wb_r = s.wbr; kill = s.kl; kill_r = s.klr; flush = s.fl;
  endtask

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Instance 0 has the writeback bypass, instance 1 does not.
  function automatic bit model_pend(int b, int x);
    if (mcnt[b][x] == 0) return 1'b0;
    if (b == 0 && wb && int'(wb_r) == x && mcnt[b][x] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit model_reserved(int b);
    bit haz;
    haz = (use_r0 && model_pend(b, int'(r0))) || (use_r1 && model_pend(b, int'(r1))) ||
          (w_reserve && mcnt[b][int'(r0)] == CMAX);
    return v && haz;
  endfunction

  task automatic model_clear();
    for (int b = 0; b < 2; b++) begin
      for (int n = 0; n < NREG; n++) mcnt[b][n] = 0;
      merr[b] = 1'b0;
    end
  endtask

  task automatic step();
    bit er [2];
    logic [31:0] eb;
    bit rsv;
    int d, nv;
    #1;
    for (int b = 0; b < 2; b++) begin
      er[b] = model_reserved(b);
      eb = '0;
      for (int n = 0; n < NREG; n++) eb[n] = (mcnt[b][n] != 0);
      check_output($sformatf("model.reserved[%0d]", b), (b == 0) ? res0 : res1, er[b]);
      check_output($sformatf("model.busy[%0d]", b), (b == 0) ? busy0 : busy1, eb);
      check_output($sformatf("model.idle[%0d]", b), (b == 0) ? idle0 : idle1, (eb == 0));
      check_output($sformatf("model.err[%0d]", b), (b == 0) ? err0 : err1, merr[b]);
    end
    @(posedge clk);
    if (reset) begin
      model_clear();
    end else begin
      for (int b = 0; b < 2; b++) begin
        rsv = v && issue && w_reserve && !er[b] && !flush;
        for (int n = 0; n < NREG; n++) begin
          d = int'(rsv && int'(r0) == n) - int'(wb && int'(wb_r) == n) - int'(kill && int'(kill_r) == n);
          nv = mcnt[b][n] + d;
          if (nv < 0) begin
            nv = 0;
            merr[b] = 1'b1;
          end
          mcnt[b][n] = nv;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    //           rst v iss wr u0 u1 r0 r1 wb wbr k kr fl | res busy       idle err
    vec.push_back(mk(1, 1, 1, 1, 0, 0, 3, 0, 0, 0, 0, 0, 0,  0, 32'h0,   1, 0));
    vec.push_back(mk(0, 1, 1, 1, 0, 0, 3, 0, 0, 0, 0, 0, 0,  0, 32'h0,   1, 0));
    vec.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0,  0, 32'h8,   0, 0));
    vec.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h0,   1, 0));
    vec.push_back(mk(0, 1, 1, 1, 0, 0, 7, 0, 0, 0, 0, 0, 0,  0, 32'h0,   1, 0));
    vec.push_back(mk(0, 1, 1, 1, 0, 0, 7, 0, 0, 0, 0, 0, 0,  0, 32'h80,  0, 0));
    vec.push_back(mk(0, 1, 1, 1, 0, 0, 7, 0, 0, 0, 0, 0, 0,  0, 32'h80,  0, 0));
    vec.push_back(mk(0, 1, 1, 1, 0, 0, 7, 0, 0, 0, 0, 0, 0,  1, 32'h80,  0, 0));
    vec.push_back(mk(0, 1, 1, 1, 0, 0, 7, 0, 1, 7, 0, 0, 0,  1, 32'h80,  0, 0));
    vec.push_back(mk(0, 1, 1, 1, 0, 0, 7, 0, 0, 0, 0, 0, 0,  0, 32'h80,  0, 0));
    vec.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0,  0, 32'h80,  0, 0));
    vec.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0,  0, 32'h80,  0, 0));
    vec.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0,  0, 32'h80,  0, 0));
    vec.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h0,   1, 0));
    vec.push_back(mk(0, 1, 1, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0,  0, 32'h0,   1, 0));
    vec.push_back(mk(0, 1, 1, 1, 0, 0, 2, 0, 1, 2, 0, 0, 0,  0, 32'h4,   0, 0));
    vec.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0,  0, 32'h4,   0, 0));
    vec.push_back(mk(0, 1, 1, 1, 0, 0, 4, 0, 0, 0, 0, 0, 0,  0, 32'h0,   1, 0));
    vec.push_back(mk(0, 1, 1, 1, 0, 0, 4, 0, 0, 0, 0, 0, 0,  0, 32'h10,  0, 0));
    vec.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 1, 4, 0,  0, 32'h10,  0, 0));
    vec.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h0,   1, 0));
    vec.push_back(mk(0, 1, 1, 1, 0, 0, 9, 0, 0, 0, 0, 0, 1,  0, 32'h0,   1, 0));
    vec.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0,  0, 32'h0,   1, 0));
    vec.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h0,   1, 1));
    vec.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h0,   1, 1));
    vec.push_back(mk(0, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 32'h0,   1, 1));
    vec.push_back(mk(0, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 32'h2,   0, 1));
    vec.push_back(mk(0, 1, 1, 1, 0, 0, 8, 0, 0, 0, 0, 0, 0,  0, 32'h2,   0, 1));
    vec.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0,  0, 32'h102, 0, 1));
    vec.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h0,   1, 0));

    // Power-up: one reset edge establishes known state before anything is compared.
    apply_stimulus(vec[0]);
    @(posedge clk);
    model_clear();
    @(negedge clk);

    for (int i = 0; i < vec.size(); i++) begin
      apply_stimulus(vec[i]);
      #1;
      check_output($sformatf("vec%0d.reserved", i), res0, vec[i].e_res);
      check_output($sformatf("vec%0d.busy", i), busy0, vec[i].e_busy);
      check_output($sformatf("vec%0d.idle", i), idle0, vec[i].e_idle);
      check_output($sformatf("vec%0d.err", i), err0, vec[i].e_err);
      step();
    end

    // RAW on r5: the bypass instance drops the hazard in the writeback cycle, the other one cycle later.
    apply_stimulus(mk(0, 1, 1, 1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    apply_stimulus(mk(0, 1, 1, 0, 0, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check_output("raw.hold.byp", res0, 1'b1);
    check_output("raw.hold.nobyp", res1, 1'b1);
    step();
    apply_stimulus(mk(0, 1, 1, 0, 0, 1, 0, 5, 1, 5, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check_output("raw.wb.byp", res0, 1'b0);
    check_output("raw.wb.nobyp", res1, 1'b1);
    step();
    apply_stimulus(mk(0, 1, 1, 0, 0, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check_output("raw.after.byp", res0, 1'b0);
    check_output("raw.after.nobyp", res1, 1'b0);
    step();

    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 63) == 0);
      v         = ($urandom_range(0, 3) != 0);
      issue     = ($urandom_range(0, 3) != 0);
      w_reserve = $urandom_range(0, 1);
      use_r0    = $urandom_range(0, 1);
      use_r1    = $urandom_range(0, 1);
      r0        = 5'($urandom_range(0, 7));
      r1        = 5'($urandom_range(0, 7));
      wb        = ($urandom_range(0, 2) == 0);
      wb_r      = 5'($urandom_range(0, 7));
      kill      = ($urandom_range(0, 9) == 0);
      kill_r    = 5'($urandom_range(0, 7));
      flush     = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) r0 = 5'($urandom_range(0, 31));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
